// File: rtl/rainbow_pkg.sv
// Shared types for the rainbow sequencer: FSM states, hue phases and phase stepping.
package rainbow_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    P0 = 3'd0,
    P1 = 3'd1,
    P2 = 3'd2,
    P3 = 3'd3,
    P4 = 3'd4,
    P5 = 3'd5
  } phase_t;

  localparam int NUM_PHASES = 6;

  function automatic phase_t next_phase(input phase_t p);
    if (int'(p) >= NUM_PHASES - 1) return P0;
    return phase_t'(p + 3'd1);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Ramp step timer: counts run cycles and pulses tick on the last count of each step.
// Holding run low freezes the count, so a paused sequence resumes mid-step.
module tick_gen #(
  parameter int STEP_COUNTER_MAX = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int CW = $clog2(STEP_COUNTER_MAX) + 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_COUNTER_MAX - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = run && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (run) count_d = tick ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

endmodule

// File: rtl/rainbow_sequencer.sv
// Hue-wheel sequencer producing R/G/B duty words for three PWM channels.
// Duties are decoded purely from registered state, phase and ramp.
module rainbow_sequencer
  import rainbow_pkg::*;
#(
  parameter int DUTY_RES         = 8,
  parameter int STEP_COUNTER_MAX = 2500000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                hold,
  output logic [DUTY_RES:0]   duty_r,
  output logic [DUTY_RES:0]   duty_g,
  output logic [DUTY_RES:0]   duty_b,
  output logic [2:0]          phase,
  output logic                wrap,
  output logic                busy
);

  localparam logic [DUTY_RES:0]   MAX_W    = {1'b1, {DUTY_RES{1'b0}}};
  localparam logic [DUTY_RES-1:0] RAMP_TOP = '1;

  state_t              state_q, state_d;
  phase_t              phase_q, phase_d;
  logic [DUTY_RES-1:0] ramp_q, ramp_d;
  logic                wrap_q, wrap_d;
  logic                tick, run, tick_rst;
  logic [DUTY_RES:0]   rp, fl;

  assign run = (state_q == RUN);
  // Step count is wiped at the same edge the FSM falls back to IDLE.
  assign tick_rst = rst && (state_d != IDLE);

  tick_gen #(.STEP_COUNTER_MAX(STEP_COUNTER_MAX)) u_tick_gen (
    .clk  (clk),
    .rst  (tick_rst),
    .run  (run),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = IDLE; else if (hold) state_d = HOLD;
      HOLD:    if (!en) state_d = IDLE; else if (!hold) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    ramp_d  = ramp_q;
    wrap_d  = 1'b0;
    if (state_d == IDLE) begin
      phase_d = P0;
      ramp_d  = '0;
    end else if (tick) begin
      if (ramp_q == RAMP_TOP) begin
        ramp_d  = '0;
        phase_d = next_phase(phase_q);
        wrap_d  = (phase_q == P5);
      end else begin
        ramp_d = ramp_q + DUTY_RES'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      phase_q <= P0;
      ramp_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      ramp_q  <= ramp_d;
      wrap_q  <= wrap_d;
    end
  end

  // ramp never exceeds MAX-1, so the falling edge stays within 1..MAX.
  assign rp = {1'b0, ramp_q};
  assign fl = MAX_W - rp;

  always_comb begin
    duty_r = '0;
    duty_g = '0;
    duty_b = '0;
    if (state_q != IDLE) begin
      case (phase_q)
        P0:      begin duty_r = MAX_W; duty_g = rp;    end
        P1:      begin duty_r = fl;    duty_g = MAX_W; end
        P2:      begin duty_g = MAX_W; duty_b = rp;    end
        P3:      begin duty_g = fl;    duty_b = MAX_W; end
        P4:      begin duty_r = rp;    duty_b = MAX_W; end
        P5:      begin duty_r = MAX_W; duty_b = fl;    end
        default: ;
      endcase
    end
  end

  assign phase = phase_q;
  assign wrap  = wrap_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: doc/rainbow_sequencer.md
RAINBOW_SEQUENCER -- requirements
Module: rainbow_sequencer

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-002 The parameter DUTY_RES SHALL default to 8 and set the duty resolution, with MAX = 2**DUTY_RES.
REQ-003 The parameter STEP_COUNTER_MAX SHALL default to 2500000 and set the clk cycles per ramp step; legal values are >= 1.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  synchronous reset, active low.
REQ-006 en  input  1  run enable; 0 forces IDLE.
REQ-007 hold  input  1  freeze the sequence while en=1.
REQ-008 duty_r, duty_g, duty_b  output  DUTY_RES+1 each  duty words (0..MAX) for three downstream PWM channels.
REQ-009 phase  output  3  current hue phase, 0..5.
REQ-010 wrap  output  1  one-cycle pulse on a P5->P0 transition.
REQ-011 busy  output  1  high in RUN or HOLD.

Function
REQ-012 FSM states SHALL be IDLE, RUN and HOLD.
REQ-013 FSM transitions SHALL be: IDLE->RUN on en=1; RUN->HOLD on en=1 & hold=1; HOLD->RUN on en=1 & hold=0; RUN/HOLD->IDLE on en=0. en=0 SHALL take priority over hold.
REQ-014 Step counter: in RUN only, count 0..STEP_COUNTER_MAX-1; tick SHALL be high in the cycle where count==STEP_COUNTER_MAX-1, after which count returns to 0.
REQ-015 Step counter in HOLD: count and ramp SHALL be frozen, and the remaining count SHALL be preserved.
REQ-016 Ramp register: width DUTY_RES, values 0..MAX-1; it SHALL increment on tick.
REQ-017 Phase advance: on tick with ramp==MAX-1, ramp SHALL go to 0 and phase SHALL advance (5 wraps to 0).
REQ-018 Duty decode in RUN/HOLD (rp = ramp, fl = MAX-ramp):
  P0: R=MAX, G=rp, B=0
  P1: R=fl, G=MAX, B=0
  P2: R=0, G=MAX, B=rp
  P3: R=0, G=fl, B=MAX
  P4: R=rp, G=0, B=MAX
  P5: R=MAX, G=0, B=fl
REQ-019 In IDLE, all duty outputs SHALL be 0.
REQ-020 Duty outputs SHALL be decoded only from registered state, phase and ramp, with no combinational path from en or hold.
REQ-021 Continuity: across any tick, including phase boundaries and the P5->P0 wrap, no duty output SHALL change by more than 1.
REQ-022 On entering IDLE, phase, ramp and count SHALL clear to 0, so a re-enable always starts at P0, ramp 0.
REQ-023 wrap SHALL be registered and high for exactly the one cycle in which phase==0 and ramp==0 following the P5 advance; it SHALL never assert on an IDLE->RUN start.
REQ-024 Latency: en sampled high at edge k gives RUN (busy=1, R=MAX) after edge k; the first tick occurs STEP_COUNTER_MAX cycles later.
REQ-025 With STEP_COUNTER_MAX=1, tick SHALL be high every RUN cycle.

Reset
REQ-026 With rst=0 at a clk edge, the block SHALL enter IDLE with phase=0, ramp=0, count=0, wrap=0, busy=0 and duty_r/g/b=0.
REQ-027 Reset SHALL override en, hold and tick in the same cycle, including mid-phase.

Structure
REQ-028 The shared package rainbow_pkg SHALL hold the state_t enum (IDLE, RUN, HOLD), the phase_t enum (P0..P5) and the constant NUM_PHASES=6.
REQ-029 The step counter SHALL be one sub-module, tick_gen (params STEP_COUNTER_MAX; ports clk, rst, run, tick), with counter width $clog2(STEP_COUNTER_MAX)+1.
REQ-030 All duty arithmetic SHALL be unsigned DUTY_RES+1 bits, and MAX-ramp SHALL never underflow.

Verification (bench parameters DUTY_RES=2 (MAX=4), STEP_COUNTER_MAX=3)
REQ-031 Reset: rst=0 for 2 cycles with en=1 -> duty 0/0/0, phase 0, busy 0, wrap 0.
REQ-032 Start: en=1 -> R=4, G=0, B=0 immediately; G=1 after 3 cycles, G=3 after 9 cycles; phase=1 with R=4, G=4 after 12 cycles.
REQ-033 Full cycle: en=1 for 72 cycles -> wrap high exactly once at cycle 72 with phase=0 and R=4/G=0/B=0; every tick changes each channel by at most 1.
REQ-034 Hold: assert hold for 10 cycles in P2 one cycle after a tick -> outputs and count frozen; after release, the next tick arrives 2 cycles later.
REQ-035 Disable: en=0 with hold=1 during P3 -> next cycle IDLE, duty 0/0/0, phase 0; en=1 again -> R=4, G=0, B=0, phase 0, no wrap.
REQ-036 Reset mid-run: rst=0 for 1 cycle in P4 coincident with a tick -> IDLE, all outputs 0, no phase advance.
